piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parametrised parallel-in/serial-out serializer with valid/ready load handshake.
//  Accepts a WIDTH-bit word, shifts it out one bit per enabled cycle in either bit order,
//  and flags valid/last bits; reloads back-to-back on the last bit for gap-free streams.
//  Sits between a word producer (register file/FIFO) and a bit-serial link or test port.
// PARAMETERS
//  WIDTH       8  word width in bits, >= 1
//  LSB_FIRST   1  1: bit 0 shifted out first; 0: bit WIDTH-1 first
//  IDLE_LEVEL  0  value driven on ser_data when no bit is valid
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  par_data   in   WIDTH  parallel word to serialize
//  par_valid  in   1      par_data valid
//  par_ready  out  1      serializer can accept a word this cycle (combinational)
//  shift_en   in   1      bit-rate strobe: current bit consumed when 1
//  abort      in   1      synchronous flush of the word in flight
//  ser_data   out  1      serial bit (registered)
//  ser_valid  out  1      ser_data carries a word bit
//  ser_last   out  1      ser_data is the final bit of the word
//  busy       out  1      word in flight (== ser_valid)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, shift reg=0, bit_cnt=0; ser_data=IDLE_LEVEL,
//    ser_valid=0, ser_last=0, busy=0; par_ready=1 after release; no transfer while rst_n=0.
//  - States: IDLE, SHIFT. bit_cnt width = max(1,$clog2(WIDTH)), counts 0..WIDTH-1.
//  - Transfer = par_valid & par_ready at a rising edge; par_data latched into shift reg.
//  - par_ready = !abort & (state==IDLE | (state==SHIFT & ser_last & shift_en)).
//  - IDLE: on transfer -> SHIFT, bit_cnt=0; next cycle ser_valid=1 and ser_data = par_data[0]
//    (LSB_FIRST=1) or par_data[WIDTH-1] (LSB_FIRST=0). Latency: 1 cycle load->first bit.
//  - SHIFT, shift_en=0: hold ser_data, bit_cnt, flags (bit stays presented).
//  - SHIFT, shift_en=1, bit_cnt<WIDTH-1: shift one place toward output end, zero-fill vacated
//    bit, bit_cnt+1. ser_last=1 exactly when bit_cnt==WIDTH-1.
//  - SHIFT, shift_en=1, bit_cnt==WIDTH-1: with transfer -> reload, bit_cnt=0, stay SHIFT
//    (zero-gap back-to-back); without transfer -> IDLE, ser_valid=0, ser_data=IDLE_LEVEL.
//  - Each word bit is presented for >=1 cycle; consumed on the edge where shift_en=1.
//  - abort=1 (any state): next edge -> IDLE, bit_cnt=0, outputs to idle values; overrides
//    shift_en and load (par_ready forced 0, so no word is accepted and lost).
//  - shift_en in IDLE ignored. par_data changes while not transferred have no effect.
//  - WIDTH=1: every valid bit has ser_last=1; back-to-back still gap-free.
//  - Reset mid-word: word discarded immediately, outputs to reset values asynchronously.
// TESTING
//  1 WIDTH=8,LSB_FIRST=1, load 8'hA5, shift_en=1 constant -> ser_data 1,0,1,0,0,1,0,1 on 8
//    consecutive cycles, ser_last on 8th only, then ser_valid=0, ser_data=IDLE_LEVEL.
//  2 LSB_FIRST=0, load 8'hA5 -> ser_data 1,0,1,0,0,1,0,1 (MSB first), same flag timing.
//  3 par_valid held, words 8'h01 then 8'h80, shift_en=1 -> 16 contiguous valid bits, par_ready
//    pulses only on 8th bit cycle, no idle cycle between words.
//  4 shift_en 1-in-3 strobe, load 8'h3C -> each bit held 3 cycles, order unchanged, 24 cycles.
//  5 abort asserted at bit 4 of 8'hFF with par_valid=1 -> next cycle ser_valid=0,
//    par_ready=0 during abort, word not accepted; after release new load starts at bit 0.
//  6 rst_n pulled low mid-word (async, between edges) -> outputs to reset values at once;
//    WIDTH=1 build: load 1,0,1 back-to-back -> ser_last=1 every valid cycle.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: loads a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per shift_en strobe, reloading gap-free on the last bit.
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] par_data,
  input  logic             par_valid,
  output logic             par_ready,
  input  logic             shift_en,
  input  logic             abort,
  output logic             ser_data,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
  localparam logic           ST_IDLE  = 1'b0;
  localparam logic           ST_SHIFT = 1'b1;

  logic             state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_last_q, ser_last_d;
  logic             load;
  logic [WIDTH-1:0] shifted;

  // Bit at the output end of the register for the configured bit order.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  // Ready also during the consuming cycle of the last bit, so a new word follows with no gap.
  assign par_ready = !abort &&
                     ((state_q == ST_IDLE) || ((state_q == ST_SHIFT) && ser_last_q && shift_en));
  assign load      = par_valid && par_ready;
  assign shifted   = shift_once(shreg_q);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    ser_data_d = ser_data_q;
    ser_last_d = ser_last_q;
    if (abort) begin
      state_d    = ST_IDLE;
      shreg_d    = '0;
      bit_cnt_d  = '0;
      ser_data_d = IDLE_LEVEL;
      ser_last_d = 1'b0;
    end else if (load) begin
      state_d    = ST_SHIFT;
      shreg_d    = par_data;
      bit_cnt_d  = '0;
      ser_data_d = out_bit(par_data);
      ser_last_d = (LAST_CNT == '0);
    end else if ((state_q == ST_SHIFT) && shift_en) begin
      if (ser_last_q) begin
        state_d    = ST_IDLE;
        shreg_d    = '0;
        bit_cnt_d  = '0;
        ser_data_d = IDLE_LEVEL;
        ser_last_d = 1'b0;
      end else begin
        shreg_d    = shifted;
        bit_cnt_d  = bit_cnt_q + CW'(1);
        ser_data_d = out_bit(shifted);
        ser_last_d = ((bit_cnt_q + CW'(1)) == LAST_CNT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      ser_data_q <= IDLE_LEVEL;
      ser_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      ser_data_q <= ser_data_d;
      ser_last_q <= ser_last_d;
    end
  end

  assign ser_data  = ser_data_q;
  assign ser_valid = (state_q == ST_SHIFT);
  assign ser_last  = ser_last_q;
  assign busy      = ser_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first and MSB-first 8-bit builds plus a 1-bit build.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pd [2];
  logic       pv [2];
  logic       se [2];
  logic       ab [2];
  logic       pr [2];
  logic       sd [2];
  logic       sv [2];
  logic       sl [2];
  logic       bz [2];

  logic [0:0] pd_c;
  logic       pv_c, se_c, ab_c, pr_c, sd_c, sv_c, sl_c, bz_c;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .par_data(pd[0]), .par_valid(pv[0]), .par_ready(pr[0]),
    .shift_en(se[0]), .abort(ab[0]), .ser_data(sd[0]), .ser_valid(sv[0]),
    .ser_last(sl[0]), .busy(bz[0])
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .par_data(pd[1]), .par_valid(pv[1]), .par_ready(pr[1]),
    .shift_en(se[1]), .abort(ab[1]), .ser_data(sd[1]), .ser_valid(sv[1]),
    .ser_last(sl[1]), .busy(bz[1])
  );

  piso_serializer #(.WIDTH(1), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .par_data(pd_c), .par_valid(pv_c), .par_ready(pr_c),
    .shift_en(se_c), .abort(ab_c), .ser_data(sd_c), .ser_valid(sv_c),
    .ser_last(sl_c), .busy(bz_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects word w just loaded on instance k with shift_en held high; walks all 8 bits.
  task automatic check_word(input int k, input logic [7:0] w, input string tag);
    pv[k] = 1'b0;
    se[k] = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      check_eq({tag, "_valid"}, sv[k], 1'b1);
      check_eq({tag, "_data"},  sd[k], (k == 0) ? w[i] : w[7-i]);
      check_eq({tag, "_last"},  sl[k], (i == 7));
      check_eq({tag, "_ready"}, pr[k], (i == 7));
      step();
    end
    check_eq({tag, "_end_valid"}, sv[k], 1'b0);
    check_eq({tag, "_end_data"},  sd[k], 1'b0);
    check_eq({tag, "_end_busy"},  bz[k], 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    for (int k = 0; k < 2; k++) begin
      pd[k] = '0; pv[k] = 1'b0; se[k] = 1'b0; ab[k] = 1'b0;
    end
    pd_c = '0; pv_c = 1'b0; se_c = 1'b0; ab_c = 1'b0;

    // Reset state
    step();
    step();
    check_eq("rst_valid", sv[0], 1'b0);
    check_eq("rst_data",  sd[0], 1'b0);
    check_eq("rst_last",  sl[0], 1'b0);
    check_eq("rst_busy",  bz[0], 1'b0);
    rst_n = 1'b1;
    step();
    check_eq("rst_ready", pr[0], 1'b1);
    check_eq("rst_ready_w1", pr_c, 1'b1);

    // Test 1: LSB first, 8'hA5
    pv[0] = 1'b1; pd[0] = 8'hA5; se[0] = 1'b1;
    step();
    check_word(0, 8'hA5, "t1");

    // Test 2: MSB first, 8'hA5 and 8'h01 (order-sensitive)
    pv[1] = 1'b1; pd[1] = 8'hA5; se[1] = 1'b1;
    step();
    check_word(1, 8'hA5, "t2a");
    pv[1] = 1'b1; pd[1] = 8'h01;
    step();
    check_word(1, 8'h01, "t2b");

    // Test 3: back-to-back 8'h01 then 8'h80 with par_valid held
    pv[0] = 1'b1; pd[0] = 8'h01; se[0] = 1'b1;
    step();
    pd[0] = 8'h80;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) pv[0] = 1'b0;
      #1;
      w = (i < 8) ? 8'h01 : 8'h80;
      check_eq("t3_valid", sv[0], 1'b1);
      check_eq("t3_data",  sd[0], w[i%8]);
      check_eq("t3_last",  sl[0], ((i % 8) == 7));
      check_eq("t3_ready", pr[0], ((i % 8) == 7));
      step();
    end
    check_eq("t3_end_valid", sv[0], 1'b0);

    // Test 4: 1-in-3 strobe, 8'h3C
    pv[0] = 1'b1; pd[0] = 8'h3C; se[0] = 1'b0;
    step();
    pv[0] = 1'b0;
    w = 8'h3C;
    for (int c = 0; c < 24; c++) begin
      se[0] = ((c % 3) == 2);
      check_eq("t4_valid", sv[0], 1'b1);
      check_eq("t4_data",  sd[0], w[c/3]);
      check_eq("t4_last",  sl[0], ((c / 3) == 7));
      step();
    end
    check_eq("t4_end_valid", sv[0], 1'b0);
    check_eq("t4_end_data",  sd[0], 1'b0);

    // Test 5: abort at bit 4 of 8'hFF with a word pending
    pv[0] = 1'b1; pd[0] = 8'hFF; se[0] = 1'b1;
    step();
    pv[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("t5_pre_data", sd[0], 1'b1);
      step();
    end
    ab[0] = 1'b1; pv[0] = 1'b1; pd[0] = 8'h0F;
    #1;
    check_eq("t5_ready_abort", pr[0], 1'b0);
    step();
    check_eq("t5_valid", sv[0], 1'b0);
    check_eq("t5_data",  sd[0], 1'b0);
    check_eq("t5_last",  sl[0], 1'b0);
    check_eq("t5_busy",  bz[0], 1'b0);
    ab[0] = 1'b0;
    #1;
    check_eq("t5_ready_rel", pr[0], 1'b1);
    step();
    check_word(0, 8'h0F, "t5_new");

    // Test 6: asynchronous reset mid-word
    pv[0] = 1'b1; pd[0] = 8'hFF; se[0] = 1'b1;
    step();
    pv[0] = 1'b0;
    step();
    step();
    check_eq("t6_pre_valid", sv[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_valid", sv[0], 1'b0);
    check_eq("t6_data",  sd[0], 1'b0);
    check_eq("t6_busy",  bz[0], 1'b0);
    #3;
    rst_n = 1'b1;
    step();
    check_eq("t6_after_valid", sv[0], 1'b0);
    check_eq("t6_after_ready", pr[0], 1'b1);

    // WIDTH=1: words 1,0,1 back-to-back
    pv_c = 1'b1; pd_c = 1'b1; se_c = 1'b1;
    step();
    pd_c = 1'b0;
    #1;
    check_eq("w1_valid0", sv_c, 1'b1);
    check_eq("w1_data0",  sd_c, 1'b1);
    check_eq("w1_last0",  sl_c, 1'b1);
    check_eq("w1_ready0", pr_c, 1'b1);
    step();
    pd_c = 1'b1;
    #1;
    check_eq("w1_valid1", sv_c, 1'b1);
    check_eq("w1_data1",  sd_c, 1'b0);
    check_eq("w1_last1",  sl_c, 1'b1);
    step();
    pv_c = 1'b0;
    #1;
    check_eq("w1_valid2", sv_c, 1'b1);
    check_eq("w1_data2",  sd_c, 1'b1);
    check_eq("w1_last2",  sl_c, 1'b1);
    step();
    check_eq("w1_end_valid", sv_c, 1'b0);
    check_eq("w1_end_last",  sl_c, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
